param_bus_arbiter: RTL and testbench
====================================

PARAM_BUS_ARBITER -- requirements
Module: param_bus_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 7, meaning the parameter address width.
REQ-002 The module SHALL have parameter SEL_W, default 5, meaning the select lines {com,m2,m1,osc,env}.
REQ-003 The module SHALL have parameter STROBE_LEN, default 2, meaning the read/write strobe width in cycles; legal range 1..15.
REQ-004 Port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cpu_req, input, 1 bit: CPU transaction request, held until cpu_ack.
REQ-007 Port cpu_we, input, 1 bit: CPU transaction type; 1 = write, 0 = read.
REQ-008 Port cpu_addr, input, ADDR_W bits: CPU parameter address.
REQ-009 Port cpu_sel, input, SEL_W bits: CPU select lines.
REQ-010 Port cpu_wdata, input, 8 bits: CPU write data.
REQ-011 Port cpu_ack, output, 1 bit: single-cycle pulse marking CPU transaction completion.
REQ-012 Port cpu_rdata, output, 8 bits: CPU read result, valid from cpu_ack onward.
REQ-013 Ports dec_req, dec_we, dec_addr, dec_sel, dec_wdata, dec_ack and dec_rdata SHALL mirror the cpu_* ports for the MIDI/sysex decoder requester.
REQ-014 Port adr, output, ADDR_W bits: address to the synth engine.
REQ-015 Port sel, output, SEL_W bits: select lines to the synth engine.
REQ-016 Port write, output, 1 bit: write strobe.
REQ-017 Port read, output, 1 bit: read strobe.
REQ-018 Port data_out, output, 8 bits: write data to the engine.
REQ-019 Port data_in, input, 8 bits: read data from the engine.
REQ-020 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-021 Port grant_dec, output, 1 bit: owner of the current transaction; 1 = decoder, 0 = CPU.

Function
REQ-022 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD.
- IDLE -> SETUP on any sampled request.
- SETUP -> STROBE after 1 cycle.
- STROBE -> HOLD after STROBE_LEN cycles.
- HOLD -> IDLE after 1 cycle.
REQ-023 In IDLE, the block SHALL register the winner's we/addr/sel/wdata into internal latches; the requester's inputs are ignored after that edge.
REQ-024 Arbitration SHALL be round-robin.
- Only one requester active: that requester is granted.
- Both active in the same cycle: the requester not granted last wins.
- After reset, the last-grant pointer SHALL equal decoder, so the CPU wins the first tie.
REQ-025 adr, sel and data_out SHALL be driven from the latches during SETUP, STROBE and HOLD, and SHALL be 0 in IDLE.
REQ-026 write (if we=1) or read (if we=0) SHALL be high for exactly the STROBE cycles; both SHALL never be high together and SHALL be low in SETUP and HOLD.
REQ-027 For reads, the block SHALL capture data_in on the last STROBE cycle into the owner's rdata register.
- The non-owner's rdata register SHALL be unchanged.
- Writes SHALL leave both rdata registers unchanged.
REQ-028 The owner's ack SHALL pulse high for exactly the HOLD cycle; the other ack stays low.
REQ-029 Latency SHALL be fixed: with the request sampled in IDLE at cycle N, SETUP is N+1, STROBE is N+2..N+1+STROBE_LEN, and ack is N+2+STROBE_LEN.
REQ-030 The earliest next grant SHALL be sampled at N+3+STROBE_LEN, giving back-to-back throughput of one transaction per STROBE_LEN+3 cycles.
REQ-031 A requester holding req high through its ack cycle SHALL NOT be double-served; req sampled in the cycle after ack counts as a new request.
REQ-032 A request deasserted before being sampled in IDLE SHALL be dropped with no ack.
REQ-033 A request arriving while busy SHALL wait; no request SHALL be lost if held.
REQ-034 busy SHALL equal (state != IDLE); grant_dec SHALL be held from SETUP through HOLD and be 0 in IDLE.

Reset
REQ-035 On reset, the FSM SHALL enter IDLE and the last-grant pointer SHALL be set to decoder.
REQ-036 On reset, adr, sel, data_out, write, read, busy, grant_dec, cpu_ack, dec_ack, cpu_rdata and dec_rdata SHALL all be 0.
REQ-037 Reset asserted mid-transaction SHALL abort it within the reset cycle: strobes drop next edge, no ack issues, and the aborted transaction is not retried.

Verification
REQ-038 CPU write alone, STROBE_LEN=2: addr=0x12, sel=00100, wdata=0xA5 at N -> write high N+2..N+3, adr=0x12, data_out=0xA5, cpu_ack at N+4, dec_ack never.
REQ-039 Decoder read: engine drives data_in=0x3C during STROBE -> read high 2 cycles, dec_rdata=0x3C at ack, cpu_rdata unchanged.
REQ-040 Simultaneous cpu_req and dec_req, both held, after reset -> CPU served first (ack at N+4), decoder granted at sample N+5 (ack at N+9), cpu_req re-held wins the next tie after the decoder.
REQ-041 Reset asserted during the second STROBE cycle -> write low next edge, no ack, all outputs 0; a request re-asserted after reset is served with normal latency.
REQ-042 cpu_req pulsed for 1 cycle while busy with a decoder transaction -> no CPU transaction and no cpu_ack.
REQ-043 STROBE_LEN=1 and STROBE_LEN=15 sweep -> strobe width equals STROBE_LEN, ack at N+2+STROBE_LEN, read and write never overlap.

Source files
------------

// File: rtl/param_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : param_bus_arbiter
// Brief  : Round-robin arbiter between a CPU and a MIDI/sysex decoder for
//          a strobed 8-bit parameter bus to the synth engine.
// Rev    : 1.0  initial release
// ============================================================================
module param_bus_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int SEL_W      = 5,
    parameter int STROBE_LEN = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [SEL_W-1:0]  cpu_sel,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dec_req,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [SEL_W-1:0]  dec_sel,
    input  logic [7:0]        dec_wdata,
    output logic              dec_ack,
    output logic [7:0]        dec_rdata,
    output logic [ADDR_W-1:0] adr,
    output logic [SEL_W-1:0]  sel,
    output logic              write,
    output logic              read,
    output logic [7:0]        data_out,
    input  logic [7:0]        data_in,
    output logic              busy,
    output logic              grant_dec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] c_strobe_last = 4'(STROBE_LEN - 1);

    state_t             r_state_q,     w_state_d;
    logic [3:0]         r_cnt_q,       w_cnt_d;
    logic               r_last_dec_q,  w_last_dec_d;
    logic               r_owner_dec_q, w_owner_dec_d;
    logic               r_we_q,        w_we_d;
    logic [ADDR_W-1:0]  r_addr_q,      w_addr_d;
    logic [SEL_W-1:0]   r_sel_q,       w_sel_d;
    logic [7:0]         r_wdata_q,     w_wdata_d;
    logic [7:0]         r_cpu_rdata_q, w_cpu_rdata_d;
    logic [7:0]         r_dec_rdata_q, w_dec_rdata_d;
    logic               w_pick_dec;

    // On a tie the requester that did not win last time takes the bus.
    assign w_pick_dec = (cpu_req && dec_req) ? ~r_last_dec_q : dec_req;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_last_dec_d  = r_last_dec_q;
        w_owner_dec_d = r_owner_dec_q;
        w_we_d        = r_we_q;
        w_addr_d      = r_addr_q;
        w_sel_d       = r_sel_q;
        w_wdata_d     = r_wdata_q;
        w_cpu_rdata_d = r_cpu_rdata_q;
        w_dec_rdata_d = r_dec_rdata_q;
        case (r_state_q)
            IDLE: begin
                if (cpu_req || dec_req) begin
                    w_state_d     = SETUP;
                    w_owner_dec_d = w_pick_dec;
                    w_last_dec_d  = w_pick_dec;
                    w_we_d        = w_pick_dec ? dec_we    : cpu_we;
                    w_addr_d      = w_pick_dec ? dec_addr  : cpu_addr;
                    w_sel_d       = w_pick_dec ? dec_sel   : cpu_sel;
                    w_wdata_d     = w_pick_dec ? dec_wdata : cpu_wdata;
                end
            end
            SETUP: begin
                w_state_d = STROBE;
                w_cnt_d   = 4'd0;
            end
            STROBE: begin
                if (r_cnt_q == c_strobe_last) begin
                    w_state_d = HOLD;
                    if (!r_we_q) begin
                        if (r_owner_dec_q) w_dec_rdata_d = data_in;
                        else               w_cpu_rdata_d = data_in;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
            HOLD:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= 4'd0;
            r_last_dec_q  <= 1'b1;
            r_owner_dec_q <= 1'b0;
            r_we_q        <= 1'b0;
            r_addr_q      <= '0;
            r_sel_q       <= '0;
            r_wdata_q     <= 8'd0;
            r_cpu_rdata_q <= 8'd0;
            r_dec_rdata_q <= 8'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_last_dec_q  <= w_last_dec_d;
            r_owner_dec_q <= w_owner_dec_d;
            r_we_q        <= w_we_d;
            r_addr_q      <= w_addr_d;
            r_sel_q       <= w_sel_d;
            r_wdata_q     <= w_wdata_d;
            r_cpu_rdata_q <= w_cpu_rdata_d;
            r_dec_rdata_q <= w_dec_rdata_d;
        end
    end

    assign busy      = (r_state_q != IDLE);
    assign grant_dec = busy && r_owner_dec_q;
    assign adr       = busy ? r_addr_q  : '0;
    assign sel       = busy ? r_sel_q   : '0;
    assign data_out  = busy ? r_wdata_q : 8'd0;
    assign write     = (r_state_q == STROBE) &&  r_we_q;
    assign read      = (r_state_q == STROBE) && !r_we_q;
    assign cpu_ack   = (r_state_q == HOLD) && !r_owner_dec_q;
    assign dec_ack   = (r_state_q == HOLD) &&  r_owner_dec_q;
    assign cpu_rdata = r_cpu_rdata_q;
    assign dec_rdata = r_dec_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_param_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_param_bus_arbiter
// Brief  : Three arbiters (STROBE_LEN 1, 2, 15) on shared stimulus, each
//          compared every cycle against a transaction-offset model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_param_bus_arbiter;

    localparam int NI = 3;

    logic       CLOCK_50;
    logic       reset;
    logic       cpu_req, cpu_we, dec_req, dec_we;
    logic [6:0] cpu_addr, dec_addr;
    logic [4:0] cpu_sel, dec_sel;
    logic [7:0] cpu_wdata, dec_wdata, data_in;

    logic       cpu_ack_a [NI];
    logic       dec_ack_a [NI];
    logic [7:0] cpu_rdata_a [NI];
    logic [7:0] dec_rdata_a [NI];
    logic [6:0] adr_a [NI];
    logic [4:0] sel_a [NI];
    logic       write_a [NI];
    logic       read_a [NI];
    logic [7:0] data_out_a [NI];
    logic       busy_a [NI];
    logic       grant_dec_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        param_bus_arbiter #(
            .ADDR_W    (7),
            .SEL_W     (5),
            .STROBE_LEN((g == 0) ? 1 : ((g == 1) ? 2 : 15))
        ) u_dut (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .cpu_req  (cpu_req),
            .cpu_we   (cpu_we),
            .cpu_addr (cpu_addr),
            .cpu_sel  (cpu_sel),
            .cpu_wdata(cpu_wdata),
            .cpu_ack  (cpu_ack_a[g]),
            .cpu_rdata(cpu_rdata_a[g]),
            .dec_req  (dec_req),
            .dec_we   (dec_we),
            .dec_addr (dec_addr),
            .dec_sel  (dec_sel),
            .dec_wdata(dec_wdata),
            .dec_ack  (dec_ack_a[g]),
            .dec_rdata(dec_rdata_a[g]),
            .adr      (adr_a[g]),
            .sel      (sel_a[g]),
            .write    (write_a[g]),
            .read     (read_a[g]),
            .data_out (data_out_a[g]),
            .data_in  (data_in),
            .busy     (busy_a[g]),
            .grant_dec(grant_dec_a[g])
        );
    end

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Model: a transaction granted at cycle S occupies cycles S+1..S+L+2,
    // strobes on S+2..S+L+1, acks on S+L+2.
    bit         m_active [NI];
    int         m_start [NI];
    bit         m_owner [NI];
    bit         m_last [NI];
    bit         m_we [NI];
    logic [6:0] m_addr [NI];
    logic [4:0] m_sel [NI];
    logic [7:0] m_wdata [NI];
    logic [7:0] m_crd [NI];
    logic [7:0] m_drd [NI];
    int         cyc;
    int         n_chk;
    int         n_fail;

    function automatic int sl_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (STROBE_LEN=%0d) cycle %0d: got %0h, expected %0h",
                     name, sl_of(inst), cyc, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int k;
            k = cyc - m_start[i];
            if (reset) begin
                m_active[i] = 1'b0;
                m_last[i]   = 1'b1;
                m_crd[i]    = 8'd0;
                m_drd[i]    = 8'd0;
            end else if (!m_active[i]) begin
                if (cpu_req || dec_req) begin
                    m_owner[i]  = (cpu_req && dec_req) ? !m_last[i] : dec_req;
                    m_last[i]   = m_owner[i];
                    m_we[i]     = m_owner[i] ? dec_we    : cpu_we;
                    m_addr[i]   = m_owner[i] ? dec_addr  : cpu_addr;
                    m_sel[i]    = m_owner[i] ? dec_sel   : cpu_sel;
                    m_wdata[i]  = m_owner[i] ? dec_wdata : cpu_wdata;
                    m_start[i]  = cyc;
                    m_active[i] = 1'b1;
                end
            end else begin
                if (k == sl_of(i) + 1 && !m_we[i]) begin
                    if (m_owner[i]) m_drd[i] = data_in;
                    else            m_crd[i] = data_in;
                end
                if (k == sl_of(i) + 2) m_active[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            int k;
            bit stb, hold;
            k    = cyc - m_start[i];
            stb  = m_active[i] && (k >= 2) && (k <= sl_of(i) + 1);
            hold = m_active[i] && (k == sl_of(i) + 2);
            check("busy",      i, busy_a[i],      m_active[i]);
            check("grant_dec", i, grant_dec_a[i], m_active[i] && m_owner[i]);
            check("adr",       i, adr_a[i],       m_active[i] ? m_addr[i]  : 7'd0);
            check("sel",       i, sel_a[i],       m_active[i] ? m_sel[i]   : 5'd0);
            check("data_out",  i, data_out_a[i],  m_active[i] ? m_wdata[i] : 8'd0);
            check("write",     i, write_a[i],     stb &&  m_we[i]);
            check("read",      i, read_a[i],      stb && !m_we[i]);
            check("cpu_ack",   i, cpu_ack_a[i],   hold && !m_owner[i]);
            check("dec_ack",   i, dec_ack_a[i],   hold &&  m_owner[i]);
            check("cpu_rdata", i, cpu_rdata_a[i], m_crd[i]);
            check("dec_rdata", i, dec_rdata_a[i], m_drd[i]);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_update();
        @(negedge CLOCK_50);
        compare_all();
    endtask

    task automatic settle(input int n);
        cpu_req = 1'b0;
        dec_req = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive_cpu(input logic we, input logic [6:0] a,
                             input logic [4:0] s, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_sel = s; cpu_wdata = d;
    endtask

    task automatic drive_dec(input logic we, input logic [6:0] a,
                             input logic [4:0] s, input logic [7:0] d);
        dec_req = 1'b1; dec_we = we; dec_addr = a; dec_sel = s; dec_wdata = d;
    endtask

    initial begin
        int ack_at [NI];
        int width [NI];
        cyc = 0; n_chk = 0; n_fail = 0;
        for (int i = 0; i < NI; i++) begin
            m_active[i] = 1'b0; m_start[i] = 0; m_owner[i] = 1'b0; m_last[i] = 1'b1;
            m_we[i] = 1'b0; m_addr[i] = 7'd0; m_sel[i] = 5'd0; m_wdata[i] = 8'd0;
            m_crd[i] = 8'd0; m_drd[i] = 8'd0;
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 7'd0; cpu_sel = 5'd0; cpu_wdata = 8'd0;
        dec_req = 1'b0; dec_we = 1'b0; dec_addr = 7'd0; dec_sel = 5'd0; dec_wdata = 8'd0;
        data_in = 8'd0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy",      1, busy_a[1],      0);
        check("rst_write",     1, write_a[1],     0);
        check("rst_cpu_rdata", 1, cpu_rdata_a[1], 0);
        check("rst_dec_rdata", 1, dec_rdata_a[1], 0);
        step();

        // CPU write alone
        drive_cpu(1'b1, 7'h12, 5'b00100, 8'hA5);
        step();
        check("w_setup_write", 1, write_a[1], 0);
        check("w_setup_adr",   1, adr_a[1],   7'h12);
        step();
        check("w_strobe1",   1, write_a[1],    1);
        check("w_data_out",  1, data_out_a[1], 8'hA5);
        step();
        check("w_strobe2",   1, write_a[1],    1);
        step();
        check("w_cpu_ack",   1, cpu_ack_a[1],  1);
        check("w_dec_ack",   1, dec_ack_a[1],  0);
        check("w_hold_write", 1, write_a[1],   0);
        cpu_req = 1'b0;
        step();
        check("w_idle", 1, busy_a[1], 0);
        settle(20);

        // Decoder read
        drive_dec(1'b0, 7'h05, 5'b00001, 8'h00);
        data_in = 8'h3C;
        step();
        step();
        check("r_strobe1", 1, read_a[1], 1);
        step();
        check("r_strobe2", 1, read_a[1], 1);
        step();
        check("r_dec_ack",   1, dec_ack_a[1],   1);
        check("r_dec_rdata", 1, dec_rdata_a[1], 8'h3C);
        check("r_cpu_rdata", 1, cpu_rdata_a[1], 8'h00);
        settle(20);

        // Simultaneous requests after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_in = 8'h77;
        drive_cpu(1'b1, 7'h21, 5'b00010, 8'h11);
        drive_dec(1'b0, 7'h22, 5'b01000, 8'h00);
        repeat (4) step();
        check("tie_cpu_ack",  1, cpu_ack_a[1],   1);
        check("tie_cpu_gnt",  1, grant_dec_a[1], 0);
        cpu_req = 1'b0;
        step();
        check("tie_gap_idle", 1, busy_a[1], 0);
        step();
        check("tie_dec_gnt",  1, grant_dec_a[1], 1);
        cpu_req = 1'b1;
        repeat (3) step();
        check("tie_dec_ack",   1, dec_ack_a[1],   1);
        check("tie_dec_rdata", 1, dec_rdata_a[1], 8'h77);
        step();
        step();
        check("tie2_cpu_wins", 1, grant_dec_a[1], 0);
        check("tie2_busy",     1, busy_a[1],      1);
        settle(20);

        // Reset in the second strobe cycle aborts the write
        drive_cpu(1'b1, 7'h33, 5'b10000, 8'h5A);
        repeat (3) step();
        check("abort_strobe2", 1, write_a[1], 1);
        reset = 1'b1;
        cpu_req = 1'b0;
        step();
        check("abort_write", 1, write_a[1],   0);
        check("abort_ack",   1, cpu_ack_a[1], 0);
        check("abort_adr",   1, adr_a[1],     0);
        reset = 1'b0;
        step();
        check("abort_no_ack", 1, cpu_ack_a[1], 0);
        drive_cpu(1'b1, 7'h34, 5'b10000, 8'h5B);
        repeat (4) step();
        check("retry_ack", 1, cpu_ack_a[1], 1);
        settle(20);

        // CPU pulse while busy is dropped
        drive_dec(1'b1, 7'h40, 5'b00001, 8'h99);
        step();
        drive_cpu(1'b0, 7'h41, 5'b00001, 8'h00);
        step();
        cpu_req = 1'b0;
        repeat (2) step();
        check("pulse_dec_ack", 1, dec_ack_a[1], 1);
        check("pulse_cpu_ack", 1, cpu_ack_a[1], 0);
        dec_req = 1'b0;
        step();
        step();
        check("pulse_no_txn", 1, busy_a[1], 0);
        settle(20);

        // Strobe-length sweep: one-cycle read request on all instances
        data_in = 8'hC3;
        drive_cpu(1'b0, 7'h7F, 5'b11111, 8'h00);
        for (int i = 0; i < NI; i++) begin ack_at[i] = -1; width[i] = 0; end
        step();
        cpu_req = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (t > 1) step();
            for (int i = 0; i < NI; i++) begin
                if (read_a[i]) width[i]++;
                if (cpu_ack_a[i] && ack_at[i] < 0) ack_at[i] = t;
            end
        end
        for (int i = 0; i < NI; i++) begin
            check("sweep_ack_latency", i, ack_at[i], sl_of(i) + 2);
            check("sweep_strobe_width", i, width[i], sl_of(i));
        end
        settle(20);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cpu_req   = ($urandom_range(0, 2) == 0);
            dec_req   = ($urandom_range(0, 2) == 0);
            cpu_we    = 1'($urandom);
            dec_we    = 1'($urandom);
            cpu_addr  = 7'($urandom);
            dec_addr  = 7'($urandom);
            cpu_sel   = 5'($urandom);
            dec_sel   = 5'($urandom);
            cpu_wdata = 8'($urandom);
            dec_wdata = 8'($urandom);
            data_in   = 8'($urandom);
            step();
        end
        reset = 1'b0;
        settle(20);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
